// File: rtl/mem_stage_if.sv
// mem_stage_if: EX bundle, data-memory port and WB bundle of the memory stage.
interface mem_stage_if;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] rd_data;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic [31:0] wb_rd_data;
  logic        bus_err;
  logic        misalign_err;
  modport master (
    output in_valid, alu_op, rd_addr, rd_we, rd_data, mem_addr, store_data, dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rd_addr, wb_rd_we,
           wb_rd_data, bus_err, misalign_err
  );
  modport slave (
    input  in_valid, alu_op, rd_addr, rd_we, rd_data, mem_addr, store_data, dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rd_addr, wb_rd_we,
           wb_rd_data, bus_err, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory stage issuing LW/SW on a req/ack port with an ack watchdog.
// Optional MEM_MISALIGN_TRAP_EN: misaligned LW/SW trap via misalign_err instead of truncating.
module mem_stage #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_W          = 5,
  parameter logic [3:0]  LW_ALU         = 4'd10,
  parameter logic [3:0]  SW_ALU         = 4'd11
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd_addr;
  logic             r_rd_we;
  logic             w_mem, w_mis, w_issue, w_tmo;
  assign w_mem = bus.in_valid && (bus.alu_op == LW_ALU || bus.alu_op == SW_ALU);
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis = bus.mem_addr[1:0] != 2'b00;
`else
  assign w_mis = 1'b0;
`endif
  assign w_issue = w_mem && !w_mis;
  assign w_tmo   = TIMEOUT_CYCLES > 0 && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign bus.stall = r_state == IDLE ? w_issue : !bus.dmem_ack && !w_tmo;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_rd_addr        <= '0;
      r_rd_we          <= 1'b0;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= '0;
      bus.dmem_wdata   <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd_addr   <= '0;
      bus.wb_rd_we     <= 1'b0;
      bus.wb_rd_data   <= '0;
      bus.bus_err      <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.bus_err      <= 1'b0;
      bus.misalign_err <= 1'b0;
      if (r_state == IDLE) begin
        if (w_issue) begin
          r_state        <= WAIT;
          r_cnt          <= '0;
          r_rd_addr      <= bus.rd_addr;
          r_rd_we        <= bus.rd_we && bus.rd_addr != 5'd0 && bus.alu_op == LW_ALU;
          bus.dmem_req   <= 1'b1;
          bus.dmem_we    <= bus.alu_op == SW_ALU;
          bus.dmem_addr  <= bus.mem_addr & ~32'h3;
          bus.dmem_wdata <= bus.store_data;
        end else if (bus.in_valid) begin
          // trapped misaligned accesses retire here like ALU ops, without a register write
          bus.wb_valid     <= 1'b1;
          bus.wb_rd_addr   <= bus.rd_addr;
          bus.wb_rd_we     <= bus.rd_we && bus.rd_addr != 5'd0 && !w_mem;
          bus.wb_rd_data   <= bus.rd_data;
          bus.misalign_err <= w_mem;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (bus.dmem_ack || w_tmo) begin
          r_state        <= IDLE;
          bus.dmem_req   <= 1'b0;
          bus.wb_valid   <= 1'b1;
          bus.wb_rd_addr <= r_rd_addr;
          bus.wb_rd_we   <= bus.dmem_ack && r_rd_we;
          bus.wb_rd_data <= bus.dmem_ack && !bus.dmem_we ? bus.dmem_rdata : '0;
          bus.bus_err    <= !bus.dmem_ack;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized memory-stage traffic checked every cycle against a per-cycle expectation map.
module tb_mem_stage;
  localparam int         TMO = 16;
  localparam logic [3:0] LW  = 4'd10;
  localparam logic [3:0] SW  = 4'd11;
  typedef struct {logic [4:0] addr; logic we; logic [31:0] data; logic chk_data;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] last_addr = '0;
  wb_t  exp_wb[int];
  req_t exp_req[int];
  bit   exp_stall[int];
  bit   exp_bus[int];
  bit   exp_mis[int];
  mem_stage_if bus();
  mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(5), .LW_ALU(LW), .SW_ALU(SW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.dmem_req) last_addr = bus.dmem_addr;
      chk("stall", 32'(bus.stall), 32'(exp_stall.exists(cyc)));
      chk("dmem_req", 32'(bus.dmem_req), 32'(exp_req.exists(cyc)));
      if (exp_req.exists(cyc)) begin
        chk("dmem_we", 32'(bus.dmem_we), 32'(exp_req[cyc].we));
        chk("dmem_addr", bus.dmem_addr, exp_req[cyc].addr);
        chk("dmem_wdata", bus.dmem_wdata, exp_req[cyc].wdata);
      end
      chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wb.exists(cyc)));
      if (exp_wb.exists(cyc)) begin
        chk("wb_rd_addr", 32'(bus.wb_rd_addr), 32'(exp_wb[cyc].addr));
        chk("wb_rd_we", 32'(bus.wb_rd_we), 32'(exp_wb[cyc].we));
        if (exp_wb[cyc].chk_data) chk("wb_rd_data", bus.wb_rd_data, exp_wb[cyc].data);
      end
      chk("bus_err", 32'(bus.bus_err), 32'(exp_bus.exists(cyc)));
      chk("misalign_err", 32'(bus.misalign_err), 32'(exp_mis.exists(cyc)));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.alu_op     = 4'($urandom);
    bus.rd_addr    = 5'($urandom);
    bus.mem_addr   = $urandom;
    bus.dmem_rdata = $urandom;
    step();
    bus.dmem_ack = 1'b0;
  endtask
  // dly = cycles from request edge to ack; dly >= TMO means no ack (watchdog), late = stray ack afterwards
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic we, input logic [31:0] data,
                       input logic [31:0] addr, input logic [31:0] sd, input int dly, input logic late,
                       input logic [31:0] rv);
    int c, n;
    logic mem, mis, tmo, lw;
    c = cyc;
    bus.in_valid = 1'b1;
    bus.alu_op = op;
    bus.rd_addr = rd;
    bus.rd_we = we;
    bus.rd_data = data;
    bus.mem_addr = addr;
    bus.store_data = sd;
    mem = op == LW || op == SW;
    lw = op == LW;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem && addr[1:0] != 2'b00;
`endif
    if (!mem || mis) begin
      exp_wb[c+1] = '{rd, we && rd != 0 && !mem, data, 1'b1};
      if (mis) exp_mis[c+1] = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
    end else begin
      tmo = dly >= TMO;
      n = tmo ? TMO : dly + 1;
      exp_stall[c] = 1'b1;
      for (int i = 1; i <= n; i++) begin
        exp_req[c+i] = '{op == SW, addr & ~32'h3, sd};
        if (i < n) exp_stall[c+i] = 1'b1;
      end
      exp_wb[c+n+1] = '{rd, !tmo && lw && we && rd != 0, (tmo || !lw) ? 32'h0 : rv, !tmo};
      if (tmo) exp_bus[c+n+1] = 1'b1;
      for (int i = 1; i <= n; i++) begin
        step();
        bus.dmem_ack = i == n && !tmo;
        bus.dmem_rdata = i == n ? rv : $urandom;
      end
      step();
      bus.dmem_ack = late;
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.alu_op = 4'd0;
    bus.rd_addr = 5'd0;
    bus.rd_we = 1'b0;
    bus.rd_data = '0;
    bus.mem_addr = '0;
    bus.store_data = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    repeat (3) step();
    chk("rst dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst wb_rd_data", bus.wb_rd_data, 32'd0);
    chk("rst bus_err", 32'(bus.bus_err), 32'd0);
    chk("rst stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle();
    issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 1'b0, 32'h0);
    chk("alu wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("alu wb_rd_addr", 32'(bus.wb_rd_addr), 32'd5);
    chk("alu wb_rd_data", bus.wb_rd_data, 32'h1234);
    issue(LW, 5'd7, 1'b1, 32'h0, 32'h100, 32'h0, 3, 1'b0, 32'hDEADBEEF);
    chk("lw wb_rd_data", bus.wb_rd_data, 32'hDEADBEEF);
    chk("lw wb_rd_we", 32'(bus.wb_rd_we), 32'd1);
    chk("lw addr", last_addr, 32'h100);
    issue(SW, 5'd9, 1'b1, 32'h0, 32'h40, 32'hA5A5A5A5, 0, 1'b0, 32'h0);
    chk("sw wb_rd_we", 32'(bus.wb_rd_we), 32'd0);
    issue(LW, 5'd4, 1'b1, 32'h0, 32'h80, 32'h0, 20, 1'b1, 32'h11112222);
    chk("tmo bus_err", 32'(bus.bus_err), 32'd1);
    chk("tmo wb_rd_we", 32'(bus.wb_rd_we), 32'd0);
    chk("tmo dmem_req", 32'(bus.dmem_req), 32'd0);
    idle();
    issue(LW, 5'd6, 1'b1, 32'h0, 32'hC0, 32'h0, TMO - 1, 1'b0, 32'h33334444);
    chk("ack-wins bus_err", 32'(bus.bus_err), 32'd0);
    chk("ack-wins data", bus.wb_rd_data, 32'h33334444);
    issue(LW, 5'd8, 1'b1, 32'h0, 32'h102, 32'h0, 1, 1'b0, 32'h55556666);
`ifndef MEM_MISALIGN_TRAP_EN
    chk("misalign addr", last_addr, 32'h100);
`endif
    issue(4'd0, 5'd0, 1'b1, 32'hFFFF, 32'h0, 32'h0, 0, 1'b0, 32'h0);
    chk("x0 wb_rd_we", 32'(bus.wb_rd_we), 32'd0);
    for (int k = 0; k < 200; k++) begin
      int kind, dly;
      logic [3:0] op;
      kind = $urandom_range(0, 3);
      op = kind == 0 ? LW : kind == 1 ? SW : 4'($urandom_range(0, 9));
      dly = $urandom_range(0, 7) == 0 ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 5);
      issue(op, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, dly, 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    chk_en = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_op = LW;
    bus.rd_addr = 5'd3;
    bus.rd_we = 1'b1;
    bus.mem_addr = 32'h200;
    step();
    chk("rstw req up", 32'(bus.dmem_req), 32'd1);
    step();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    chk("rstw dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rstw wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rstw stall", 32'(bus.stall), 32'd0);
    step();
    bus.dmem_ack = 1'b0;
    chk("late ack wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("late ack req", 32'(bus.dmem_req), 32'd0);
    chk("late ack bus_err", 32'(bus.bus_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the RISC-V pipeline. It consumes the EX-stage result bundle: rd address, write enable, ALU result, memory address, alu_op and store data.
- LW/SW: issues word transactions on a req/ack data-memory port.
- All other ops: passed through to a registered WB-stage interface.
- While a memory access is outstanding, it stalls upstream.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait for dmem_ack after request; 0 disables the watchdog.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  EX bundle valid this cycle
alu_op  input  4  operation code; `LW_ALU / `SW_ALU from riscv_define_all.v select memory ops
rd_addr  input  5  destination register
rd_we  input  1  register write enable
rd_data  input  32  ALU result (non-memory ops)
mem_addr  input  32  computed memory address
store_data  input  32  rs2 value for SW
stall  output  1  upstream must hold its bundle (combinational)
dmem_req  output  1  memory request, held until ack or timeout
dmem_we  output  1  1 = store
dmem_addr  output  32  word address
dmem_wdata  output  32  store data
dmem_ack  input  1  one-cycle completion strobe
dmem_rdata  input  32  load data, valid with dmem_ack
wb_valid  output  1  WB bundle valid (registered, 1-cycle pulse per instruction)
wb_rd_addr  output  5  WB destination
wb_rd_we  output  1  WB write enable
wb_rd_data  output  32  WB data
bus_err  output  1  one-cycle pulse on timeout
misalign_err  output  1  one-cycle pulse on misaligned access (see optional feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, counter 0. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, bus_err, misalign_err.
- FSM has two states, IDLE and WAIT.
- IDLE, in_valid=0:
  - wb_valid=0 next cycle.
  - stall=0.
- IDLE, in_valid=1, non-memory op:
  - Next edge: wb_valid=1, wb_rd_addr/wb_rd_we/wb_rd_data taken from the inputs. Latency is 1 cycle.
  - stall=0.
- IDLE, in_valid=1, LW or SW:
  - stall=1 in this cycle.
  - Next edge: capture rd_addr and rd_we. Drive dmem_req=1, dmem_we=(op==SW), dmem_addr=mem_addr, dmem_wdata=store_data. Clear counter, go to WAIT.
  - wb_valid=0.
- WAIT:
  - dmem_req/we/addr/wdata are held stable.
  - stall = !dmem_ack && !timeout_hit.
  - Counter increments each cycle.
- WAIT with dmem_ack=1:
  - Next edge: dmem_req=0, state IDLE, wb_valid=1.
  - LW: wb_rd_data=dmem_rdata, wb_rd_we=captured rd_we.
  - SW: wb_rd_we=0, wb_rd_data=0.
  - stall is low in the ack cycle, so upstream advances exactly once per instruction.
- WAIT with timeout: when TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with no ack:
  - Next edge: dmem_req=0, bus_err=1 for one cycle, wb_valid=1 with wb_rd_we=0, state IDLE.
  - stall is low in that cycle.
- Register x0: wb_rd_we is forced to 0 whenever wb_rd_addr==0.
- dmem_ack while in IDLE is ignored.
- dmem_ack and timeout in the same cycle: ack wins, no bus_err.
- reset asserted during WAIT: next edge drops dmem_req and returns to IDLE with no WB write. A late ack afterwards is ignored.
- Back-to-back memory ops: minimum of 2 cycles each (request edge + ack edge); there are no overlapping requests.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: in IDLE, an LW/SW with mem_addr[1:0]!=0 issues no bus request.
  - Next edge: misalign_err=1 (one cycle), wb_valid=1, wb_rd_we=0.
  - stall=0; the op completes like an ALU op.
- Undefined: dmem_addr[1:0] is forced to 2'b00 (word-aligned truncation), and misalign_err is tied 0.

Test Plan:
- ALU passthrough: ADD_ALU, rd_addr=5, rd_we=1, rd_data=0x1234 -> next cycle wb_valid=1, wb_rd_addr=5, wb_rd_data=0x1234, stall=0, dmem_req=0.
- LW, ack after 3 cycles: mem_addr=0x100, rd_addr=7, dmem_rdata=0xDEADBEEF -> dmem_req high with addr 0x100, we=0; stall high until the ack cycle; next cycle wb_rd_data=0xDEADBEEF, wb_rd_we=1; exactly one WB pulse.
- SW, immediate ack: mem_addr=0x40, store_data=0xA5A5A5A5 -> dmem_we=1, wdata=0xA5A5A5A5; then wb_valid=1 with wb_rd_we=0.
- Timeout: LW with no ack, TIMEOUT_CYCLES=16 -> req drops after 16 WAIT cycles, bus_err pulses once, wb_rd_we=0, stall low, FSM back in IDLE.
- Reset mid-WAIT: assert reset during an outstanding LW, then ack one cycle later -> dmem_req=0, wb_valid=0, no WB write.
- Misaligned LW at 0x102:
  - With MEM_MISALIGN_TRAP_EN: misalign_err=1, no dmem_req.
  - Without it: dmem_addr=0x100, misalign_err=0.
